// File: rtl/symbol_histogram.sv
// symbol_histogram: per-frame histogram of 4-bit symbols. It presents 16 packed {count, symbol} entries for a downstream sorter.
// Optional macro HIST_SAT_EN: counts saturate and a sticky ovf is raised; otherwise counts wrap and ovf is 0.
module symbol_histogram #(
  parameter int DSIZE  = 18,
  parameter int OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_sym,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] freq0,
  output logic [DSIZE-1:0] freq1,
  output logic [DSIZE-1:0] freq2,
  output logic [DSIZE-1:0] freq3,
  output logic [DSIZE-1:0] freq4,
  output logic [DSIZE-1:0] freq5,
  output logic [DSIZE-1:0] freq6,
  output logic [DSIZE-1:0] freq7,
  output logic [DSIZE-1:0] freq8,
  output logic [DSIZE-1:0] freq9,
  output logic [DSIZE-1:0] freq10,
  output logic [DSIZE-1:0] freq11,
  output logic [DSIZE-1:0] freq12,
  output logic [DSIZE-1:0] freq13,
  output logic [DSIZE-1:0] freq14,
  output logic [DSIZE-1:0] freq15,
  output logic             ovf
);

  localparam int CW = DSIZE - OFFSET;

  typedef enum logic {COUNT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt [16];
  logic [DSIZE-1:0] freq [16];

  // Handshake flags decode straight from the state flop, so they never glitch.
  assign in_ready  = (state == COUNT);
  assign out_valid = (state == DONE);

  // NOTE: the 16 counters are discrete flops rather than a RAM. Their async clear on reset is therefore legal, and it is required here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COUNT;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      case (state)
        COUNT: begin
          if (in_valid) begin
`ifdef HIST_SAT_EN
            if (cnt[in_sym] != '1) cnt[in_sym] <= cnt[in_sym] + CW'(1);
`else
            cnt[in_sym] <= cnt[in_sym] + CW'(1);
`endif
            if (in_last) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= COUNT;
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
          end
        end
        default: state <= COUNT;
      endcase
    end
  end

`ifdef HIST_SAT_EN
  logic ovf_q;

  // The flag is set by an increment attempt on a full counter. It stays set until the frame is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == COUNT && in_valid && cnt[in_sym] == '1) begin
      ovf_q <= 1'b1;
    end else if (state == DONE && out_ready) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // The symbol field is a constant index, independent of state and reset.
  for (genvar k = 0; k < 16; k++) begin : g_freq
    assign freq[k] = {cnt[k], OFFSET'(k)};
  end

  assign freq0  = freq[0];
  assign freq1  = freq[1];
  assign freq2  = freq[2];
  assign freq3  = freq[3];
  assign freq4  = freq[4];
  assign freq5  = freq[5];
  assign freq6  = freq[6];
  assign freq7  = freq[7];
  assign freq8  = freq[8];
  assign freq9  = freq[9];
  assign freq10 = freq[10];
  assign freq11 = freq[11];
  assign freq12 = freq[12];
  assign freq13 = freq[13];
  assign freq14 = freq[14];
  assign freq15 = freq[15];

endmodule

// File: tb/tb_symbol_histogram.sv
// tb_symbol_histogram: table vectors, hand-written corner sequences and random frames checked against a counting model.
module tb_symbol_histogram;

  localparam int DSIZE  = 18;
  localparam int OFFSET = 8;
  localparam int CMAX   = 1023;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, in_ready, out_valid, out_ready, ovf;
  logic [3:0] in_sym;
  logic [DSIZE-1:0] f [16];
  logic [DSIZE-1:0] fq0, fq1, fq2, fq3, fq4, fq5, fq6, fq7;
  logic [DSIZE-1:0] fq8, fq9, fq10, fq11, fq12, fq13, fq14, fq15;

  int checks = 0;
  int errors = 0;
  int dead_cycles = 0;

  always #5 clk = ~clk;

  symbol_histogram #(.DSIZE(DSIZE), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .freq0(fq0), .freq1(fq1), .freq2(fq2), .freq3(fq3), .freq4(fq4), .freq5(fq5),
    .freq6(fq6), .freq7(fq7), .freq8(fq8), .freq9(fq9), .freq10(fq10), .freq11(fq11),
    .freq12(fq12), .freq13(fq13), .freq14(fq14), .freq15(fq15), .ovf(ovf)
  );

  assign f[0]  = fq0;   assign f[1]  = fq1;   assign f[2]  = fq2;   assign f[3]  = fq3;
  assign f[4]  = fq4;   assign f[5]  = fq5;   assign f[6]  = fq6;   assign f[7]  = fq7;
  assign f[8]  = fq8;   assign f[9]  = fq9;   assign f[10] = fq10;  assign f[11] = fq11;
  assign f[12] = fq12;  assign f[13] = fq13;  assign f[14] = fq14;  assign f[15] = fq15;

  typedef struct {
    logic [15:0]      syms;  // symbol i lives in nibble i
    int               n;
    int               k;
    logic [DSIZE-1:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int total();
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(f[k][DSIZE-1:OFFSET]);
    return s;
  endfunction

  // Expected counter value after 'raw' increments in one frame.
  function automatic int exp_count(input int raw);
`ifdef HIST_SAT_EN
    return (raw > CMAX) ? CMAX : raw;
`else
    return raw % (CMAX + 1);
`endif
  endfunction

  // Present one symbol and hold it until it is accepted, counting stalled cycles.
  task automatic accept(input logic [3:0] s, input logic l);
    int budget = 0;
    in_valid = 1'b1;
    in_sym   = s;
    in_last  = l;
    while (!in_ready && budget < 100) begin
      step();
      budget++;
      dead_cycles++;
    end
    if (budget >= 100) check("accept_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int m [16];
    int len, gaps, stall;
    logic [3:0] s;

    vt[0] = '{16'h3533, 4, 3,  18'h00303};
    vt[1] = '{16'h3533, 4, 5,  18'h00105};
    vt[2] = '{16'h3533, 4, 0,  18'h00000};
    vt[3] = '{16'h0009, 1, 9,  18'h00109};
    vt[4] = '{16'h0000, 4, 0,  18'h00400};
    vt[5] = '{16'hFFEF, 4, 15, 18'h0030F};
    vt[6] = '{16'h4321, 4, 2,  18'h00102};
    vt[7] = '{16'h0066, 2, 7,  18'h00007};

    rst_n = 1'b0; in_valid = 1'b0; in_sym = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 16; k++) check($sformatf("rst_freq%0d", k), 32'(f[k]), 32'(k));

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        s = vt[v].syms[4*i +: 4];
        accept(s, i == vt[v].n - 1);
      end
      check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'd0);
      check($sformatf("vec%0d_freq%0d", v, vt[v].k), 32'(f[vt[v].k]), 32'(vt[v].exp));
      check($sformatf("vec%0d_total", v), 32'(total()), 32'(vt[v].n));
      handshake();
      check($sformatf("vec%0d_clr_ready", v), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d_clr_total", v), 32'(total()), 32'd0);
    end

    // Output stall in DONE with upstream still offering a symbol
    accept(4'd3, 1'b0); accept(4'd3, 1'b0); accept(4'd5, 1'b0); accept(4'd3, 1'b1);
    in_valid = 1'b1; in_sym = 4'd1;
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_freq3", 32'(f[3]), 32'h00303);
      check("stall_freq1", 32'(f[1]), 32'h00001);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_release_ready", 32'(in_ready), 32'd1);
    check("stall_release_total", 32'(total()), 32'd0);
    in_valid = 1'b0;

    // 1024 accepts of symbol 7
    for (int i = 0; i < 1024; i++) accept(4'd7, i == 1023);
    check("sat_out_valid", 32'(out_valid), 32'd1);
    check("sat_freq7", 32'(f[7]), 32'({10'(exp_count(1024)), 8'h07}));
`ifdef HIST_SAT_EN
    check("sat_ovf", 32'(ovf), 32'd1);
`else
    check("sat_ovf", 32'(ovf), 32'd0);
`endif
    handshake();
    check("sat_clr_ovf", 32'(ovf), 32'd0);
    check("sat_clr_total", 32'(total()), 32'd0);

    // Reset mid-frame: 10 of 20 symbols accepted
    for (int i = 0; i < 10; i++) accept(4'(i + 2), 1'b0);
    check("mid_partial_total", 32'(total()), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_total", 32'(total()), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    check("mid_after_out_valid", 32'(out_valid), 32'd0);
    accept(4'd12, 1'b0); accept(4'd0, 1'b1);
    check("mid_new_out_valid", 32'(out_valid), 32'd1);
    check("mid_new_total", 32'(total()), 32'd2);
    handshake();

    // Reset while a histogram is presented
    accept(4'd2, 1'b0); accept(4'd2, 1'b1);
    check("done_pre_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_total", 32'(total()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("done_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back frames with out_ready tied high
    out_ready = 1'b1;
    dead_cycles = 0;
    accept(4'd1, 1'b0); accept(4'd1, 1'b0); accept(4'd2, 1'b1);
    check("b2b_a_out_valid", 32'(out_valid), 32'd1);
    check("b2b_a_freq1", 32'(f[1]), 32'h00201);
    check("b2b_a_freq2", 32'(f[2]), 32'h00102);
    accept(4'd4, 1'b0); accept(4'd5, 1'b1);
    check("b2b_dead_cycles", 32'(dead_cycles), 32'd1);
    check("b2b_b_freq1", 32'(f[1]), 32'h00001);
    check("b2b_b_freq4", 32'(f[4]), 32'h00104);
    check("b2b_b_freq5", 32'(f[5]), 32'h00105);
    check("b2b_b_total", 32'(total()), 32'd2);
    step();
    out_ready = 1'b0;

    // Random frames against a counting model
    for (int fr = 0; fr < 30; fr++) begin
      for (int k = 0; k < 16; k++) m[k] = 0;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          in_sym = 4'($urandom);
          step();
        end
        s = 4'($urandom);
        accept(s, i == len - 1);
        m[s]++;
      end
      check($sformatf("rnd%0d_out_valid", fr), 32'(out_valid), 32'd1);
      stall = int'($urandom_range(0, 3));
      in_valid = 1'b1;
      in_sym = 4'($urandom);
      for (int c = 0; c < stall; c++) step();
      for (int k = 0; k < 16; k++)
        check($sformatf("rnd%0d_freq%0d", fr, k), 32'(f[k]), 32'({10'(exp_count(m[k])), 8'(k)}));
      check($sformatf("rnd%0d_ovf", fr), 32'(ovf), 32'd0);
      handshake();
      in_valid = 1'b0;
      check($sformatf("rnd%0d_clr_total", fr), 32'(total()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_histogram.md
SYMBOL_HISTOGRAM -- requirements
Module: symbol_histogram

Interface
REQ-001 Parameter DSIZE, default 18: width of each packed output entry {count, symbol}.
REQ-002 Parameter OFFSET, default 8: symbol field width; the count field is DSIZE-OFFSET = 10 bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a symbol is presented on in_sym.
REQ-006 in_sym  input  4  symbol index 0..15.
REQ-007 in_last  input  1  the presented symbol is the final one of the frame.
REQ-008 in_ready  output  1  the block accepts a symbol this cycle.
REQ-009 out_valid  output  1  the histogram for a completed frame is presented.
REQ-010 out_ready  input  1  the downstream 16-way sorter stage consumes the histogram.
REQ-011 freq0..freq15  output  DSIZE each  entry k = {count_k[DSIZE-OFFSET-1:0], symbol k zero-extended to OFFSET bits}; these outputs feed the sorter inputs a0..a15 directly.
REQ-012 ovf  output  1  sticky flag: at least one count saturated in the presented frame.

Function
REQ-013 The block SHALL be a two-state FSM: COUNT (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 Accept SHALL mean in_valid && in_ready; each accept SHALL increment count[in_sym] by exactly 1 in that edge.
REQ-015 An accept with in_last=1 SHALL include that symbol in the count and move COUNT->DONE; out_valid SHALL be 1 on the next cycle (latency 1 from the last accept).
REQ-016 In DONE, freq0..freq15 and ovf SHALL be held stable until out_valid && out_ready.
REQ-017 On out_valid && out_ready, all counts and ovf SHALL clear to 0 and the FSM SHALL return to COUNT, so in_ready=1 on the following cycle.
REQ-018 in_valid asserted while in DONE SHALL be ignored (no count change); the upstream holds its symbol until in_ready.
REQ-019 In COUNT, freq outputs SHALL show the running counts; consumers SHALL sample them only on the out handshake.
REQ-020 The symbol field of freq_k SHALL be the constant k, independent of state or reset.
REQ-021 Frames SHALL contain at least one symbol; a frame of length 1 with in_last=1 SHALL yield count 1 for that symbol and 0 elsewhere.
REQ-022 Back-to-back frames: the maximum throughput SHALL be one symbol per cycle within a frame, with one dead cycle per frame (DONE) plus any out_ready stall.

Reset
REQ-023 When rst_n is asserted low, the block SHALL immediately force the FSM to COUNT, all counts to 0, ovf=0, out_valid=0, and in_ready=1 once rst_n is released.
REQ-024 Reset asserted mid-frame or in DONE SHALL discard the partial or presented histogram; no out_valid SHALL follow for that frame.

Configuration
REQ-025 Macro HIST_SAT_EN defined: counts SHALL saturate at 2^(DSIZE-OFFSET)-1 (1023), and an increment attempted at 1023 SHALL set ovf.
REQ-026 Macro HIST_SAT_EN undefined: counts SHALL wrap modulo 2^(DSIZE-OFFSET), and ovf SHALL be constant 0.

Verification
REQ-027 Reset, then symbols 3,3,5,3(last) back-to-back -> one cycle later out_valid=1, freq3=0x00303 (count 3), freq5=0x00105, freq0=0x00000, other counts 0.
REQ-028 out_ready held 0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, outputs unchanged, no counts added; out_ready=1 -> next cycle in_ready=1, all counts 0.
REQ-029 Frame of 1024 accepts of symbol 7 -> with HIST_SAT_EN, count7=1023 and ovf=1; without it, count7=0 and ovf=0.
REQ-030 rst_n pulsed low after 10 accepts of a 20-symbol frame -> all counts 0, out_valid stays 0; a new 2-symbol frame then reports exactly 2 total counts.
REQ-031 Two consecutive frames with out_ready tied to 1 -> histograms are independent, and exactly one dead cycle (in_ready=0) separates the frames.
